colors_to_bytes: RTL and testbench



---
 rtl/colors_to_bytes_pkg.sv | 28 ++
 rtl/colors_to_bytes_if.sv | 37 +++
 rtl/colors_to_bytes_byte_queue2.sv | 74 +++++++
 rtl/colors_to_bytes.sv | 119 +++++++++++
 tb/tb_colors_to_bytes.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/colors_to_bytes_pkg.sv
// Shared widths and types for the color-to-byte unpacker on the receive path.
// Two 12-bit colors carry exactly three bytes.
package colors_to_bytes_pkg;

    localparam int unsigned BYTE_LEN  = 8;
    localparam int unsigned COLOR_LEN = 12;
    localparam int unsigned NIB_LEN   = COLOR_LEN - BYTE_LEN;

    typedef logic [BYTE_LEN-1:0]  byte_t;
    typedef logic [COLOR_LEN-1:0] color_t;
    typedef logic [NIB_LEN-1:0]   nib_t;

    // PhaseHead: next color starts a byte triple; PhaseTail: a nibble is held.
    typedef enum logic {
        PhaseHead = 1'b0,
        PhaseTail = 1'b1
    } phase_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((32'd1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/colors_to_bytes_if.sv
// Color-in / byte-out stream bundle. The source side (master) drives colors and
// end-of-stream; the unpacker (slave) returns paced bytes and status.
interface colors_to_bytes_if;
    import colors_to_bytes_pkg::*;

    logic   inclk;
    color_t in;
    logic   done_in;
    byte_t  out;
    logic   outclk;
    logic   idle;
    logic   overflow;
    logic   done_out;

    modport master (
        output inclk,
        output in,
        output done_in,
        input  out,
        input  outclk,
        input  idle,
        input  overflow,
        input  done_out
    );

    modport slave (
        input  inclk,
        input  in,
        input  done_in,
        output out,
        output outclk,
        output idle,
        output overflow,
        output done_out
    );

endinterface

// File: rtl/colors_to_bytes_byte_queue2.sv
// Byte FIFO taking up to two pushes and one pop per cycle. Bytes that do not fit
// are dropped (later push first) and a sticky overflow flag is raised.
module colors_to_bytes_byte_queue2 import colors_to_bytes_pkg::*; #(
    parameter int unsigned Depth = 4,
    localparam int unsigned PtrW = clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push0_i,
    input  byte_t           data0_i,
    input  logic            push1_i,
    input  byte_t           data1_i,
    input  logic            pop_i,
    output byte_t           head_o,
    output logic [CntW-1:0] count_o,
    output logic            overflow_o
);

    byte_t           mem_q [Depth];
    logic [PtrW-1:0] wr_q;
    logic [PtrW-1:0] rd_q;
    logic [CntW-1:0] cnt_q;
    logic            ovf_q;

    logic            pop;
    logic [CntW-1:0] room;
    logic [CntW-1:0] room1;
    logic            acc0;
    logic            acc1;
    logic            drop;
    logic [PtrW-1:0] idx1;

    // The pop frees its slot before this cycle's pushes are placed.
    always_comb begin
        pop   = pop_i && (cnt_q != '0);
        room  = CntW'(Depth) - cnt_q + CntW'(pop);
        acc0  = push0_i && (room != '0);
        room1 = room - CntW'(acc0);
        acc1  = push1_i && (room1 != '0);
        idx1  = wr_q + PtrW'(acc0);
        drop  = (push0_i && !acc0) || (push1_i && !acc1);
    end

    always_ff @(posedge clk) begin
        if (acc0) begin
            mem_q[wr_q] <= data0_i;
        end
        if (acc1) begin
            mem_q[idx1] <= data1_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            wr_q  <= wr_q + PtrW'(acc0) + PtrW'(acc1);
            rd_q  <= rd_q + PtrW'(pop);
            cnt_q <= cnt_q - CntW'(pop) + CntW'(acc0) + CntW'(acc1);
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign head_o     = mem_q[rd_q];
    assign count_o    = cnt_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/colors_to_bytes.sv
// Unpacks 12-bit colors into bytes (two colors -> three bytes), queues them and
// paces them out at most one per OUT_GAP cycles; forwards end-of-stream.
module colors_to_bytes import colors_to_bytes_pkg::*; #(
    parameter int unsigned OUT_GAP     = 4,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input logic              clk,
    input logic              reset,
    colors_to_bytes_if.slave bus_io
);

    localparam int unsigned     GapW   = (OUT_GAP > 1) ? clog2(OUT_GAP) : 1;
    localparam logic [GapW-1:0] GapMax = GapW'(OUT_GAP - 1);
    localparam int unsigned     CntW   = clog2(QUEUE_DEPTH) + 1;

    phase_e          phase_q;
    phase_e          phase_d;
    nib_t            nib_q;
    nib_t            nib_d;
    logic [GapW-1:0] gap_q;
    byte_t           out_q;
    logic            outclk_q;
    logic            done_pend_q;
    logic            done_out_q;

    logic            push0;
    logic            push1;
    byte_t           data0;
    byte_t           data1;
    logic            pop;
    logic            fire;
    byte_t           q_head;
    logic [CntW-1:0] q_count;
    logic            q_ovf;

    always_comb begin
        phase_d = phase_q;
        nib_d   = nib_q;
        push0   = 1'b0;
        push1   = 1'b0;
        data0   = '0;
        data1   = '0;
        if (bus_io.inclk) begin
            push0 = 1'b1;
            if (phase_q == PhaseHead) begin
                data0   = bus_io.in[COLOR_LEN-1 -: BYTE_LEN];
                nib_d   = bus_io.in[NIB_LEN-1:0];
                phase_d = PhaseTail;
            end else begin
                data0   = {nib_q, bus_io.in[COLOR_LEN-1 -: NIB_LEN]};
                push1   = 1'b1;
                data1   = bus_io.in[BYTE_LEN-1:0];
                phase_d = PhaseHead;
            end
        end
        // Flush sees the phase after this cycle's color; it takes the next free push slot.
        if (bus_io.done_in && (phase_d == PhaseTail)) begin
            phase_d = PhaseHead;
            if (push0) begin
                push1 = 1'b1;
                data1 = {nib_d, {NIB_LEN{1'b0}}};
            end else begin
                push0 = 1'b1;
                data0 = {nib_d, {NIB_LEN{1'b0}}};
            end
        end
    end

    always_comb begin
        pop  = (q_count != '0) && (gap_q == GapMax);
        fire = done_pend_q && (q_count == '0) && !pop;
    end

    colors_to_bytes_byte_queue2 #(
        .Depth(QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push0_i   (push0),
        .data0_i   (data0),
        .push1_i   (push1),
        .data1_i   (data1),
        .pop_i     (pop),
        .head_o    (q_head),
        .count_o   (q_count),
        .overflow_o(q_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q     <= PhaseHead;
            nib_q       <= '0;
            gap_q       <= GapMax;
            out_q       <= '0;
            outclk_q    <= 1'b0;
            done_pend_q <= 1'b0;
            done_out_q  <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            nib_q    <= nib_d;
            outclk_q <= pop;
            if (pop) begin
                out_q <= q_head;
                gap_q <= '0;
            end else if (gap_q != GapMax) begin
                gap_q <= gap_q + GapW'(1);
            end
            done_pend_q <= fire ? 1'b0 : (done_pend_q | bus_io.done_in);
            done_out_q  <= fire;
        end
    end

    assign bus_io.out      = out_q;
    assign bus_io.outclk   = outclk_q;
    assign bus_io.idle     = (q_count == '0) && (phase_q == PhaseHead);
    assign bus_io.overflow = q_ovf;
    assign bus_io.done_out = done_out_q;

endmodule

// File: tb/tb_colors_to_bytes.sv
// Randomized and directed bench for colors_to_bytes against a queue-based
// reference model evaluated once per clock edge.
module tb_colors_to_bytes;

    localparam int unsigned G = 4;
    localparam int unsigned D = 4;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic reset;
    colors_to_bytes_if bus ();

    colors_to_bytes #(
        .OUT_GAP    (G),
        .QUEUE_DEPTH(D)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus_io(bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int n_done = 0;
    bq_t got;
    int got_cyc[$];

    logic [7:0] m_q[$];
    bit         m_phase;
    int         m_nib;
    int         m_gap;
    bit         m_pend;
    logic [7:0] m_out;
    bit         m_outclk, m_ovf, m_done, m_idle;

    function automatic logic [11:0] dv();
        return {bus.out, bus.outclk, bus.overflow, bus.done_out, bus.idle};
    endfunction

    function automatic logic [11:0] mv();
        return {m_out, m_outclk, m_ovf, m_done, m_idle};
    endfunction

    function automatic bit same(input bq_t a, input bq_t b);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, sample at edge+1.
    task automatic tick(input bit ic, input logic [11:0] c, input bit dn, input bit rs);
        logic [7:0] nb[$];
        bit pop, fire;
        int cv;
        bus.inclk = ic; bus.in = c; bus.done_in = dn; reset = rs;
        @(posedge clk);
        cv = int'(c);
        if (rs) begin
            m_q.delete(); m_phase = 0; m_nib = 0; m_gap = G - 1; m_pend = 0;
            m_out = 0; m_outclk = 0; m_ovf = 0; m_done = 0;
        end else begin
            pop  = (m_q.size() != 0) && (m_gap == G - 1);
            fire = m_pend && (m_q.size() == 0) && !pop;
            if (pop) begin
                m_out = m_q.pop_front(); m_outclk = 1; m_gap = 0;
            end else begin
                m_outclk = 0;
                if (m_gap < G - 1) m_gap++;
            end
            if (ic) begin
                if (!m_phase) begin
                    nb.push_back(8'(cv / 16)); m_nib = cv % 16; m_phase = 1;
                end else begin
                    nb.push_back(8'(m_nib * 16 + cv / 256)); nb.push_back(8'(cv % 256));
                    m_phase = 0;
                end
            end
            if (dn && m_phase) begin
                nb.push_back(8'(m_nib * 16)); m_phase = 0;
            end
            foreach (nb[i]) begin
                if (m_q.size() < D) m_q.push_back(nb[i]);
                else m_ovf = 1;
            end
            m_done = fire;
            m_pend = fire ? 1'b0 : (m_pend | dn);
        end
        m_idle = (m_q.size() == 0) && !m_phase;
        cyc++;
        #1;
        if (bus.outclk === 1'b1) begin got.push_back(bus.out); got_cyc.push_back(cyc); end
        if (bus.done_out === 1'b1) n_done++;
        bus.inclk = 0; bus.done_in = 0; reset = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            tick(0, 12'h0, 0, 1);
            n_chk++;
            if (dv() !== 12'h001) $display("FAIL reset_state dut=%h want=%h", dv(), 12'h001);
            else n_pass++;
        end
        tick(0, 12'h0, 0, 0);
        n_chk++;
        if (dv() !== mv()) $display("FAIL reset_idle dut=%h model=%h", dv(), mv());
        else n_pass++;
    endtask

    task automatic test_basic();
        bq_t exp = '{8'hAB, 8'hCD, 8'hEF};
        got.delete(); got_cyc.delete();
        for (int i = 0; i < 20; i++) begin
            tick(i == 0 || i == 6, (i == 0) ? 12'hABC : 12'hDEF, 0, 0);
            n_chk++;
            if (dv() !== mv()) $display("FAIL basic cyc=%0d dut=%h model=%h", cyc, dv(), mv());
            else n_pass++;
        end
        n_chk++;
        if (!same(got, exp)) $display("FAIL basic_bytes got=%p want=%p", got, exp);
        else n_pass++;
        n_chk++;
        if (got_cyc.size() != 3 || got_cyc[2] - got_cyc[1] != G)
            $display("FAIL basic_gap got=%p want spacing %0d", got_cyc, G);
        else n_pass++;
        n_chk++;
        if (bus.idle !== 1'b1 || bus.overflow !== 1'b0)
            $display("FAIL basic_status idle=%b ovf=%b want idle=1 ovf=0", bus.idle, bus.overflow);
        else n_pass++;
    endtask

    task automatic test_flush();
        bq_t exp = '{8'h12, 8'h30};
        got.delete(); n_done = 0;
        for (int i = 0; i < 14; i++) begin
            tick(i == 0, 12'h123, i == 0, 0);
            n_chk++;
            if (dv() !== mv()) $display("FAIL flush cyc=%0d dut=%h model=%h", cyc, dv(), mv());
            else n_pass++;
        end
        n_chk++;
        if (!same(got, exp)) $display("FAIL flush_bytes got=%p want=%p", got, exp);
        else n_pass++;
        n_chk++;
        if (n_done != 1) $display("FAIL flush_done pulses=%0d want=1", n_done);
        else n_pass++;
    endtask

    task automatic test_loopback();
        bq_t exp;
        logic [11:0] col[4];
        for (int b = 0; b < 6; b++) exp.push_back(8'(b));
        for (int p = 0; p < 2; p++) begin
            col[2*p]   = {exp[3*p], exp[3*p+1][7:4]};
            col[2*p+1] = {exp[3*p+1][3:0], exp[3*p+2]};
        end
        got.delete();
        for (int i = 0; i < 40; i++) begin
            tick((i % 6 == 0) && (i < 24), col[(i / 6) % 4], 0, 0);
            n_chk++;
            if (dv() !== mv()) $display("FAIL loopback cyc=%0d dut=%h model=%h", cyc, dv(), mv());
            else n_pass++;
        end
        n_chk++;
        if (!same(got, exp) || bus.overflow !== 1'b0)
            $display("FAIL loopback_bytes got=%p ovf=%b want=%p ovf=0", got, bus.overflow, exp);
        else n_pass++;
    endtask

    task automatic test_done_idle();
        got.delete();
        tick(0, 12'h0, 1, 0);
        n_chk++;
        if (bus.done_out !== 1'b0) $display("FAIL done_idle_early got=%b want=0", bus.done_out);
        else n_pass++;
        tick(0, 12'h0, 0, 0);
        n_chk++;
        if (bus.done_out !== 1'b1 || bus.outclk !== 1'b0)
            $display("FAIL done_idle_pulse done=%b outclk=%b want 1,0", bus.done_out, bus.outclk);
        else n_pass++;
        tick(0, 12'h0, 0, 0);
        n_chk++;
        if (bus.done_out !== 1'b0 || got.size() != 0)
            $display("FAIL done_idle_after done=%b bytes=%0d want 0,0", bus.done_out, got.size());
        else n_pass++;
    endtask

    task automatic test_overflow();
        bq_t stream;
        for (int k = 1; k <= 6; k += 2) begin
            stream.push_back(8'(k * 16 + k));
            stream.push_back(8'(k * 16 + k + 1));
            stream.push_back(8'((k + 1) * 16 + k + 1));
        end
        got.delete();
        for (int i = 0; i < 30; i++) begin
            tick(i < 6, 12'(('h111) * (i + 1)), 0, 0);
            n_chk++;
            if (dv() !== mv()) $display("FAIL overflow cyc=%0d dut=%h model=%h", cyc, dv(), mv());
            else n_pass++;
        end
        n_chk++;
        if (bus.overflow !== 1'b1) $display("FAIL overflow_sticky got=%b want=1", bus.overflow);
        else n_pass++;
        n_chk++;
        if (got.size() < 5 || got.size() >= stream.size() || !same(got[0:4], stream[0:4]))
            $display("FAIL overflow_prefix got=%p stream=%p", got, stream);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bq_t exp = '{8'h45, 8'h67, 8'h89};
        got.delete();
        tick(1, 12'h456, 0, 0);
        tick(0, 12'h0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            tick(0, 12'h0, 0, 0);
            n_chk++;
            if (dv() !== mv()) $display("FAIL rst_mid cyc=%0d dut=%h model=%h", cyc, dv(), mv());
            else n_pass++;
        end
        n_chk++;
        if (got.size() != 0 || bus.idle !== 1'b1 || bus.overflow !== 1'b0)
            $display("FAIL rst_mid_quiet bytes=%0d idle=%b ovf=%b want 0,1,0",
                     got.size(), bus.idle, bus.overflow);
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            tick(i == 0 || i == 6, (i == 0) ? 12'h456 : 12'h789, 0, 0);
            n_chk++;
            if (dv() !== mv()) $display("FAIL rst_mid cyc=%0d dut=%h model=%h", cyc, dv(), mv());
            else n_pass++;
        end
        n_chk++;
        if (!same(got, exp)) $display("FAIL rst_mid_bytes got=%p want=%p", got, exp);
        else n_pass++;
    endtask

    task automatic test_random();
        tick(0, 12'h0, 0, 1);
        for (int n = 0; n < 60; n++) begin
            int unsigned wait_n = $urandom_range(8, 5);
            bit dn_col = ($urandom_range(5, 0) == 0);
            bit rs = ($urandom_range(24, 0) == 0);
            tick(1, 12'($urandom), dn_col, 0);
            n_chk++;
            if (dv() !== mv()) $display("FAIL random cyc=%0d dut=%h model=%h", cyc, dv(), mv());
            else n_pass++;
            for (int w = 0; w < int'(wait_n); w++) begin
                tick(0, 12'h0, ($urandom_range(9, 0) == 0), rs && (w == 2));
                n_chk++;
                if (dv() !== mv()) $display("FAIL random cyc=%0d dut=%h model=%h", cyc, dv(), mv());
                else n_pass++;
            end
        end
        for (int i = 0; i < 16; i++) begin
            tick(0, 12'h0, i == 0, 0);
            n_chk++;
            if (dv() !== mv()) $display("FAIL random cyc=%0d dut=%h model=%h", cyc, dv(), mv());
            else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.inclk = 1'b0; bus.in = '0; bus.done_in = 1'b0;
        test_reset();
        test_basic();
        test_flush();
        test_loopback();
        test_done_idle();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
